// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, frame shift-out on
// device clock falls, ACK check and timeout, on the two shared open-drain pins.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned RTS_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       CLOCK_50,
   input  logic       KEY0,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   input  logic       ps2_clk_async,
   input  logic       ps2_data_async,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned FRAME_W = 10;
   localparam int unsigned IDX_W   = 4;

   localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RTS_LAST  = CNT_W'(RTS_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_W - 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, FINISH
   } state_t;

   state_t               state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]     idx, idx_n;
   logic [FRAME_W-1:0]   sr, sr_n;
   logic                 dat_oe_n, done_n, err_n;
   logic                 clk_meta, clk_s, clk_prev, dat_meta, dat_s;
   logic                 fall, timeout;

   // Pin synchronizers; idle-high reset keeps a spurious fall out after reset.
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         clk_meta <= 1'b1;
         clk_s    <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_s    <= 1'b1;
      end else begin
         clk_meta <= ps2_clk_async;
         clk_s    <= clk_meta;
         clk_prev <= clk_s;
         dat_meta <= ps2_data_async;
         dat_s    <= dat_meta;
      end
   end

   assign fall    = clk_prev & ~clk_s;
   assign timeout = (cnt == TO_LAST);

   // State and registered outputs; outputs follow the next state so they land with it.
   always_ff @(posedge CLOCK_50) begin
      if (!KEY0) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         sr         <= '1;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         busy       <= 1'b0;
         tx_ready   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         sr         <= sr_n;
         ps2_clk_oe <= (state_n == INHIBIT) || (state_n == RTS);
         ps2_dat_oe <= dat_oe_n;
         busy       <= (state_n != IDLE);
         tx_ready   <= (state_n == IDLE);
         done       <= done_n;
         err        <= err_n;
      end
   end

   // Next-state logic; one counter serves inhibit, RTS and the inter-fall timeout.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      sr_n     = sr;
      dat_oe_n = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;

      case (state)
         IDLE: begin
            if (tx_valid && tx_ready) begin
               state_n = INHIBIT;
               cnt_n   = '0;
               sr_n    = {1'b1, ~^tx_data, tx_data};
            end
         end
         INHIBIT: begin
            if (cnt == INH_LAST) begin
               state_n  = RTS;
               cnt_n    = '0;
               dat_oe_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         RTS: begin
            dat_oe_n = 1'b1;
            if (cnt == RTS_LAST) begin
               state_n = SEND;
               cnt_n   = '0;
               idx_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         SEND: begin
            dat_oe_n = ps2_dat_oe;
            if (timeout) begin
               err_n    = 1'b1;
               dat_oe_n = 1'b0;
               state_n  = FINISH;
            end else if (fall) begin
               dat_oe_n = ~sr[0];
               sr_n     = {1'b1, sr[FRAME_W-1:1]};
               cnt_n    = '0;
               if (idx == IDX_LAST) state_n = ACK;
               else                 idx_n   = idx + IDX_W'(1);
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ACK: begin
            if (timeout) begin
               err_n   = 1'b1;
               state_n = FINISH;
            end else if (fall) begin
               cnt_n = '0;
               if (!dat_s) begin
                  state_n = WAIT_IDLE;
               end else begin
                  err_n   = 1'b1;
                  state_n = FINISH;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            if (timeout) begin
               err_n   = 1'b1;
               state_n = FINISH;
            end else if (clk_s && dat_s) begin
               done_n  = 1'b1;
               state_n = FINISH;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         // Pulse cycle: done/err is high here, tx_ready follows one cycle later.
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pin model plus a PS/2 device model, checked
// against a frame model computed from the byte (start, LSB-first data, odd parity, stop).
module tb_ps2_host_tx;

   localparam int unsigned INH = 100;
   localparam int unsigned RTS = 16;
   localparam int unsigned TO  = 2000;

   logic       CLOCK_50 = 1'b0;
   logic       KEY0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, busy, done, err;
   logic       ps2_clk_oe, ps2_dat_oe;
   wire        ps2_clk_async;
   wire        ps2_data_async;
   logic       dev_clk, dev_dat_low;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   logic [10:0] dev_bits;

   assign ps2_clk_async  = ~ps2_clk_oe & dev_clk;
   assign ps2_data_async = ~ps2_dat_oe & ~dev_dat_low;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50(CLOCK_50), .KEY0(KEY0), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
      .ps2_clk_async(ps2_clk_async), .ps2_data_async(ps2_data_async),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pulse counters and mutual-exclusion check of done/err.
   always @(negedge CLOCK_50) begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (done || err) check("done_err_exclusive", {31'd0, done & err}, 32'd0);
   end

   // Reference frame in device sampling order: bit0 start, bits 8:1 data LSB first, 9 parity, 10 stop.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      int ones = 0;
      logic par;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      par = ((ones % 2) == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic wait_ready(input string name);
      int n = 0;
      while (!tx_ready && n < 1000) begin
         @(negedge CLOCK_50);
         n++;
      end
      check({name, "_ready"}, {31'd0, tx_ready}, 32'd1);
   endtask

   // Handshake and measure the request-to-send timing; returns in the first SEND cycle.
   task automatic send(input logic [7:0] b, input string name);
      int n = 0, n_up = -1, n_dat = -1, n_dn = -1;
      wait_ready(name);
      tx_data  = b;
      tx_valid = 1'b1;
      while (n < 400 && n_dn < 0) begin
         @(negedge CLOCK_50);
         n++;
         tx_valid = 1'b0;
         if (n_up < 0 && ps2_clk_oe) n_up = n;
         if (n_dat < 0 && ps2_dat_oe) n_dat = n;
         if (n_up > 0 && !ps2_clk_oe) n_dn = n;
      end
      check({name, "_clk_oe_rise"}, n_up, 1);
      check({name, "_dat_oe_rise"}, n_dat, INH + 1);
      check({name, "_clk_oe_fall"}, n_dn, INH + RTS + 1);
   endtask

   // Device clocking edges k0..k1 (0-based); data sampled just before each fall.
   task automatic dev_clock(input int half, input int k0, input int k1, input bit ack);
      for (int k = k0; k <= k1; k++) begin
         repeat (half) @(negedge CLOCK_50);
         dev_bits[k] = ps2_data_async;
         if (k == 10 && ack) dev_dat_low = 1'b1;
         dev_clk = 1'b0;
         repeat (half) @(negedge CLOCK_50);
         dev_clk     = 1'b1;
         dev_dat_low = 1'b0;
      end
   endtask

   typedef struct {
      logic [7:0] data;
      bit         ack;
      int         exp_done;
      int         exp_err;
      bit         exp_par;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int d0, e0, k, bad;
      logic [10:0] fr;

      vecs[0] = '{8'hED, 1'b1, 1, 0, 1'b1};
      vecs[1] = '{8'hF4, 1'b1, 1, 0, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1, 0, 1'b1};
      vecs[3] = '{8'hFF, 1'b1, 1, 0, 1'b1};
      vecs[4] = '{8'hAA, 1'b0, 0, 1, 1'b1};

      KEY0 = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      dev_clk = 1'b1; dev_dat_low = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      KEY0 = 1'b1;
      @(negedge CLOCK_50);

      // Table-driven frames.
      foreach (vecs[i]) begin
         d0 = done_cnt; e0 = err_cnt;
         send(vecs[i].data, "vec");
         dev_clock(40, 0, 10, vecs[i].ack);
         wait_ready("vec_end");
         check("vec_frame", {21'd0, dev_bits}, {21'd0, frame_of(vecs[i].data)});
         check("vec_parity", {31'd0, dev_bits[9]}, {31'd0, vecs[i].exp_par});
         check("vec_done", done_cnt - d0, vecs[i].exp_done);
         check("vec_err", err_cnt - e0, vecs[i].exp_err);
         check("vec_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      end

      // Randomized frames against the model.
      for (int r = 0; r < 8; r++) begin
         logic [7:0] b;
         int half;
         bit ack;
         b    = 8'($urandom_range(0, 255));
         half = $urandom_range(15, 60);
         ack  = ($urandom_range(0, 3) != 0);
         d0 = done_cnt; e0 = err_cnt;
         send(b, "rnd");
         dev_clock(half, 0, 10, ack);
         wait_ready("rnd_end");
         check("rnd_frame", {21'd0, dev_bits}, {21'd0, frame_of(b)});
         check("rnd_done", done_cnt - d0, ack ? 1 : 0);
         check("rnd_err", err_cnt - e0, ack ? 0 : 1);
      end

      // No ACK: err exactly one cycle after the 11th fall is detected.
      d0 = done_cnt; e0 = err_cnt;
      send(8'h55, "noack");
      dev_clock(30, 0, 9, 1'b1);
      repeat (30) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      @(negedge CLOCK_50);
      check("noack_err_n1", {31'd0, err}, 32'd0);
      @(negedge CLOCK_50);
      check("noack_err_n2", {31'd0, err}, 32'd0);
      @(negedge CLOCK_50);
      check("noack_err_n3", {31'd0, err}, 32'd1);
      check("noack_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      check("noack_ready_n3", {31'd0, tx_ready}, 32'd0);
      @(negedge CLOCK_50);
      check("noack_err_n4", {31'd0, err}, 32'd0);
      check("noack_ready_n4", {31'd0, tx_ready}, 32'd1);
      repeat (30) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      check("noack_done", done_cnt - d0, 0);
      check("noack_errcnt", err_cnt - e0, 1);

      // Timeout: device never clocks.
      d0 = done_cnt;
      send(8'h81, "to");
      k = 0;
      while (!err && k < 3000) begin
         @(negedge CLOCK_50);
         k++;
      end
      check("to_cycles", k, TO);
      check("to_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      @(negedge CLOCK_50);
      check("to_ready", {31'd0, tx_ready}, 32'd1);
      check("to_done", done_cnt - d0, 0);

      // Reset after the 4th fall, then a clean 0xFF transfer.
      d0 = done_cnt; e0 = err_cnt;
      send(8'h12, "rst");
      dev_clock(30, 0, 3, 1'b1);
      fr = frame_of(8'h12);
      check("rst_pre_dat_oe", {31'd0, ps2_dat_oe}, {31'd0, ~fr[4]});
      KEY0 = 1'b0;
      @(negedge CLOCK_50);
      check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge CLOCK_50);
      KEY0 = 1'b1;
      @(negedge CLOCK_50);
      check("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
      send(8'hFF, "rst_ff");
      dev_clock(30, 0, 10, 1'b1);
      wait_ready("rst_ff_end");
      check("rst_ff_frame", {21'd0, dev_bits}, {21'd0, frame_of(8'hFF)});
      check("rst_ff_done", done_cnt - d0, 1);

      // Busy rejection: 0xAA offered mid-SEND is ignored.
      d0 = done_cnt;
      send(8'h3C, "busy");
      dev_clock(30, 0, 1, 1'b1);
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      @(negedge CLOCK_50);
      tx_valid = 1'b0;
      dev_clock(30, 2, 10, 1'b1);
      wait_ready("busy_end");
      check("busy_frame", {21'd0, dev_bits}, {21'd0, frame_of(8'h3C)});
      check("busy_done", done_cnt - d0, 1);
      bad = 0;
      repeat (300) begin
         @(negedge CLOCK_50);
         if (busy || ps2_clk_oe) bad++;
      end
      check("busy_no_second", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
